// File: rtl/prefetch_queue_if.sv
// Bus bundle for prefetch_queue: consumer-side byte queue and memory fetch port.
// master = the prefetch queue, slave = consumer/memory environment.
interface prefetch_queue_if #(
    parameter int unsigned DATA_BYTES = 2,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                      q_valid;
    logic [7:0]                q_data;
    logic [15:0]               q_ip;
    logic                      q_ready;
    logic [CW-1:0]             q_count;

    logic                      mem_access;
    logic                      mem_ack;
    logic [19:0]               mem_address;
    logic [8*DATA_BYTES-1:0]   mem_data;

    modport master (
        output q_valid, q_data, q_ip, q_count, mem_access, mem_address,
        input  q_ready, mem_ack, mem_data
    );

    modport slave (
        input  q_valid, q_data, q_ip, q_count, mem_access, mem_address,
        output q_ready, mem_ack, mem_data
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches aligned words from cs:fetch_ip and
// hands them out one byte at a time with the IP each byte came from.
// Optional feature macro: PREFETCH_PERF_COUNTER_EN enables the perf_fetches
// counter; when undefined perf_fetches is tied to zero.
module prefetch_queue #(
    parameter int unsigned DATA_BYTES = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
    output logic [15:0] perf_fetches,
    prefetch_queue_if.master bus
);
    localparam int unsigned LW = $clog2(DATA_BYTES);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] ALIGN_MASK = 16'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   fetch_ip;
    logic [15:0]   addr_ip;
    logic [7:0]    data_q [FIFO_DEPTH];
    logic [15:0]   ip_q   [FIFO_DEPTH];
    logic [CW-1:0] count_q;
    logic          valid_q;
    logic          access_q;
    logic [19:0]   addr_q;

    logic [LW-1:0] lane;
    logic [CW-1:0] push_n;
    logic [CW-1:0] base;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] count_nxt;
    logic          pop;
    logic          do_push;
    logic [15:0]   fetch_ip_nxt;
    logic [15:0]   addr_ip_nxt;
    logic [7:0]    data_nxt [FIFO_DEPTH];
    logic [15:0]   ip_nxt   [FIFO_DEPTH];

    // Queue update: flush on branch, otherwise shift out popped head and append fetched lanes
    always_comb begin
        lane       = fetch_ip[LW-1:0];
        push_n     = CW'(DATA_BYTES) - CW'(lane);
        pop        = valid_q && bus.q_ready && !load_new_ip;
        do_push    = (state == S_REQ) && bus.mem_ack && !load_new_ip;
        base       = count_q - CW'(pop);
        free_slots = CW'(FIFO_DEPTH) - count_q;

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_nxt[i] = data_q[i];
            ip_nxt[i]   = ip_q[i];
        end

        if (load_new_ip) begin
            count_nxt    = '0;
            fetch_ip_nxt = new_ip;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_nxt[i] = '0;
                ip_nxt[i]   = '0;
            end
        end else begin
            count_nxt    = base + (do_push ? push_n : CW'(0));
            fetch_ip_nxt = do_push ? fetch_ip + 16'(push_n) : fetch_ip;
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    data_nxt[i] = data_q[i+1];
                    ip_nxt[i]   = ip_q[i+1];
                end
                data_nxt[FIFO_DEPTH-1] = '0;
                ip_nxt[FIFO_DEPTH-1]   = '0;
            end
            if (do_push) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    for (int k = 0; k < DATA_BYTES; k++) begin
                        if (k >= int'(lane) && i == int'(base) + k - int'(lane)) begin
                            data_nxt[i] = bus.mem_data[8*k +: 8];
                            ip_nxt[i]   = fetch_ip + 16'(k) - 16'(lane);
                        end
                    end
                end
            end
        end

        // Address is frozen while a request is outstanding so the bus sees a stable target
        if (state != S_IDLE && !bus.mem_ack) begin
            addr_ip_nxt = addr_ip;
        end else begin
            addr_ip_nxt = fetch_ip_nxt & ~ALIGN_MASK;
        end
    end

    // Fetch FSM, queue storage and registered bus outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            fetch_ip <= '0;
            addr_ip  <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            access_q <= 1'b0;
            addr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                ip_q[i]   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (!load_new_ip && free_slots >= CW'(DATA_BYTES)) begin
                        state    <= S_REQ;
                        access_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        state    <= S_IDLE;
                        access_q <= 1'b0;
                    end else if (load_new_ip) begin
                        state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    if (bus.mem_ack) begin
                        state    <= S_IDLE;
                        access_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    access_q <= 1'b0;
                end
            endcase
            fetch_ip <= fetch_ip_nxt;
            addr_ip  <= addr_ip_nxt;
            addr_q   <= {cs, 4'b0000} + {4'b0000, addr_ip_nxt};
            count_q  <= count_nxt;
            valid_q  <= (count_nxt != '0);
            data_q   <= data_nxt;
            ip_q     <= ip_nxt;
        end
    end

`ifdef PREFETCH_PERF_COUNTER_EN
    logic [15:0] perf_q;

    // Count fetches whose data actually entered the queue
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (do_push) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_fetches = perf_q;
`else
    assign perf_fetches = 16'h0000;
`endif

    assign bus.q_valid     = valid_q;
    assign bus.q_data      = data_q[0];
    assign bus.q_ip        = ip_q[0];
    assign bus.q_count     = count_q;
    assign bus.mem_access  = access_q;
    assign bus.mem_address = addr_q;

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter DATA_BYTES, default 2: memory bus width in bytes; legal values 2 or 4.
REQ-002 Parameter FIFO_DEPTH, default 8: byte queue depth; power of two, >= 2*DATA_BYTES.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; asserted when 0, sampled on rising clk edge.
REQ-005 cs  input  16  code segment.
REQ-006 new_ip / load_new_ip  input  16 / 1  branch target and 1-cycle load strobe.
REQ-007 q_valid / q_data / q_ip  output  1 / 8 / 16  head byte present, its value, its IP.
REQ-008 q_ready  input  1  consumer pops head when q_valid && q_ready.
REQ-009 q_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.
REQ-010 mem_access / mem_ack  output / input  1 / 1  request held high until single-cycle ack.
REQ-011 mem_address  output  20  ({cs,4'b0} + {4'b0, aligned fetch IP}) mod 2^20.
REQ-012 mem_data  input  8*DATA_BYTES  little-endian word, valid with mem_ack.
REQ-013 perf_fetches  output  16  completed, non-discarded fetch count.

Function
REQ-014 States: IDLE, REQ, ABORT; reset state IDLE.
REQ-015 IDLE->REQ when free slots (FIFO_DEPTH - q_count) >= DATA_BYTES and no load_new_ip this cycle.
REQ-016 mem_access = 1 exactly in REQ and ABORT; mem_address, cs-derived, stable while mem_access high unless cs changes.
REQ-017 Aligned fetch IP = fetch_ip with low $clog2(DATA_BYTES) bits cleared; 16-bit IP wraps 0xFFFF->0x0000 inside segment.
REQ-018 REQ + mem_ack: push bytes from lane fetch_ip[low bits] through lane DATA_BYTES-1 in that cycle; fetch_ip advances by bytes pushed (mod 2^16); ->IDLE.
REQ-019 Pushed bytes visible at head (q_valid) the cycle after mem_ack; q_ip of each byte = IP it was fetched from.
REQ-020 Pop and push in same cycle both take effect; q_count = old + pushed - popped.
REQ-021 load_new_ip: flush queue (q_count=0, q_valid=0 next cycle), fetch_ip <= new_ip; same-cycle pop ignored.
REQ-022 load_new_ip in REQ without mem_ack: ->ABORT; request stays asserted until ack.
REQ-023 ABORT + mem_ack: data discarded, no push, perf_fetches unchanged, ->IDLE.
REQ-024 load_new_ip coincident with mem_ack in REQ: data discarded, ->IDLE, fetch_ip <= new_ip.
REQ-025 load_new_ip in ABORT: fetch_ip <= new_ip, remain ABORT.
REQ-026 Queue never overflows; pushes never exceed free slots by construction of REQ-015.
REQ-027 perf_fetches increments by 1 per REQ-018 push, wraps at 0xFFFF.

Reset
REQ-028 reset low at a rising edge: state IDLE, fetch_ip 0x0000, q_count 0, perf_fetches 0.
REQ-029 Outputs while/after reset: q_valid 0, mem_access 0, q_data 0x00, q_ip 0x0000.
REQ-030 Reset mid-request aborts locally; an ack arriving in the cycle after reset release while IDLE is ignored.

Configuration
REQ-031 Macro PREFETCH_PERF_COUNTER_EN: defined -> perf_fetches counter implemented per REQ-027.
REQ-032 PREFETCH_PERF_COUNTER_EN undefined -> no counter logic; perf_fetches constant 0x0000; all other behaviour identical.

Verification
REQ-033 DATA_BYTES=2, cs=0x1000, new_ip=0x0003 load; ack mem_data=0xBBAA -> one byte 0xBB, q_ip 0x0003, next mem_address 0x10004.
REQ-034 DATA_BYTES=4, FIFO_DEPTH=8, q_ready=0, ack every request -> exactly 2 fetches then mem_access stays 0 with q_count=8.
REQ-035 load_new_ip=0x0200 while REQ, ack 3 cycles later -> no push, perf_fetches unchanged, next request mem_address {cs,0}+0x0200.
REQ-036 fetch_ip=0xFFFE, DATA_BYTES=2, cs=0xF000, ack 0x2211 -> bytes 0x11,0x22 with q_ip 0xFFFE,0xFFFF; next mem_address 0xF0000.
REQ-037 q_ready=1 continuous, 4 acks, then reset low one cycle mid-request -> all outputs at REQ-029 values, q_count 0, perf_fetches 0.
